// File: rtl/pong_pkg.sv
// Shared Pong definitions: game FSM encoding, level speed table and the
// default arena/paddle geometry also used by the renderer.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam int DEF_ARENA_X = 640;
    localparam int DEF_ARENA_Y = 480;
    localparam int DEF_ARENA_Z = 128;
    localparam int DEF_PAD_W   = 200;
    localparam int DEF_PAD_H   = 150;

    // Later levels serve faster on every axis.
    function automatic logic [2:0] base_speed(input logic [7:0] lvl);
        return (lvl >= 8'd3) ? 3'd2 : 3'd1;
    endfunction

endpackage

// File: rtl/ball_axis_check.sv
// One-axis position predictor: flags whether pos+vel leaves [0, limit)
// on either side and supplies the reflected velocity.
module ball_axis_check #(
    parameter int POS_W = 10,
    parameter int VEL_W = 6
) (
    input  logic        [POS_W-1:0] i_pos,
    input  logic signed [VEL_W-1:0] i_vel,
    input  logic        [POS_W:0]   i_limit,
    output logic                    o_reflect_lo,
    output logic                    o_reflect_hi,
    output logic signed [VEL_W-1:0] o_neg_vel
);

    logic signed [POS_W+1:0] w_nxt;

    // Two extra bits keep both underflow below zero and overflow past the limit visible.
    assign w_nxt        = $signed({2'b00, i_pos}) + $signed({{(POS_W+2-VEL_W){i_vel[VEL_W-1]}}, i_vel});
    assign o_reflect_lo = w_nxt < 0;
    assign o_reflect_hi = w_nxt >= $signed({1'b0, i_limit});
    assign o_neg_vel    = -i_vel;

endmodule

// File: rtl/ball_collision_engine.sv
// Multi-ball collision engine: per-frame wall/paddle reflection, miss
// tracking, saturating score and periodic speed-up for N_BALLS balls.
module ball_collision_engine
    import pong_pkg::*;
#(
    parameter int N_BALLS          = 2,
    parameter int POS_W            = 10,
    parameter int VEL_W            = 6,
    parameter int ARENA_X          = DEF_ARENA_X,
    parameter int ARENA_Y          = DEF_ARENA_Y,
    parameter int ARENA_Z          = DEF_ARENA_Z,
    parameter int PAD_W            = DEF_PAD_W,
    parameter int PAD_H            = DEF_PAD_H,
    parameter int SCORE_W          = 8,
    parameter int HITS_PER_SPEEDUP = 4,
    parameter int VEL_MAX          = 7
) (
    input  logic                       frame_clk,
    input  logic                       level_rst_n,
    input  logic                       pause,
    input  logic                       serve,
    input  logic [7:0]                 lvl_num,
    input  logic [N_BALLS*POS_W-1:0]   pos_x,
    input  logic [N_BALLS*POS_W-1:0]   pos_y,
    input  logic [N_BALLS*POS_W-1:0]   pos_z,
    input  logic [POS_W-1:0]           paddle_x,
    input  logic [POS_W-1:0]           paddle_y,
    output logic [N_BALLS*VEL_W-1:0]   vel_x,
    output logic [N_BALLS*VEL_W-1:0]   vel_y,
    output logic [N_BALLS*VEL_W-1:0]   vel_z,
    output logic [N_BALLS-1:0]         ball_active,
    output logic [SCORE_W-1:0]         score,
    output logic                       wall_hit,
    output logic                       paddle_hit,
    output logic                       miss,
    output logic [1:0]                 game_state
);

    localparam int HC_W = $clog2(HITS_PER_SPEEDUP + 1);
    localparam logic [POS_W:0] L_LIM_X = (POS_W+1)'(ARENA_X);
    localparam logic [POS_W:0] L_LIM_Y = (POS_W+1)'(ARENA_Y);
    localparam logic [POS_W:0] L_LIM_Z = (POS_W+1)'(ARENA_Z);
    localparam logic signed [VEL_W-1:0] L_ONE  = VEL_W'(1);
    localparam logic signed [VEL_W-1:0] L_VMAX = VEL_W'(VEL_MAX);

    state_t                  r_state;
    logic signed [VEL_W-1:0] r_vel [N_BALLS][3];
    logic [N_BALLS-1:0]      r_active;
    logic [SCORE_W-1:0]      r_score;
    logic [HC_W-1:0]         r_hit_cnt;
    logic                    r_wall;
    logic                    r_pad;
    logic                    r_miss;

    logic [POS_W-1:0]        w_pos     [N_BALLS][3];
    logic                    w_lo      [N_BALLS][3];
    logic                    w_hi      [N_BALLS][3];
    logic signed [VEL_W-1:0] w_neg     [N_BALLS][3];
    logic signed [VEL_W-1:0] w_vel_nxt [N_BALLS][3];
    logic [N_BALLS-1:0]      w_in_pad;
    logic [N_BALLS-1:0]      w_active_nxt;
    logic [POS_W:0]          w_pad_x_end;
    logic [POS_W:0]          w_pad_y_end;
    logic                    w_wall;
    logic                    w_pad;
    logic                    w_miss;
    logic [7:0]              w_pad_cnt;
    logic [7:0]              w_score_inc;
    logic [7:0]              w_hit_sum;
    logic                    w_speedup;
    logic [HC_W-1:0]         w_hit_nxt;
    logic [SCORE_W:0]        w_score_sum;
    logic [SCORE_W-1:0]      w_score_nxt;

    // Magnitude grows by one toward VEL_MAX; zero stays zero so dead balls stay still.
    function automatic logic signed [VEL_W-1:0] speed_up(input logic signed [VEL_W-1:0] v);
        if (v == '0)
            return v;
        else if (v > 0)
            return (v >= L_VMAX) ? L_VMAX : v + L_ONE;
        else
            return (v <= -L_VMAX) ? -L_VMAX : v - L_ONE;
    endfunction

    assign w_pad_x_end = {1'b0, paddle_x} + (POS_W+1)'(PAD_W);
    assign w_pad_y_end = {1'b0, paddle_y} + (POS_W+1)'(PAD_H);

    for (genvar b = 0; b < N_BALLS; b++) begin : g_ball
        assign w_pos[b][0] = pos_x[b*POS_W +: POS_W];
        assign w_pos[b][1] = pos_y[b*POS_W +: POS_W];
        assign w_pos[b][2] = pos_z[b*POS_W +: POS_W];

        assign w_in_pad[b] = ({1'b0, w_pos[b][0]} >= {1'b0, paddle_x}) &&
                             ({1'b0, w_pos[b][0]} <  w_pad_x_end) &&
                             ({1'b0, w_pos[b][1]} >= {1'b0, paddle_y}) &&
                             ({1'b0, w_pos[b][1]} <  w_pad_y_end);

        for (genvar a = 0; a < 3; a++) begin : g_axis
            ball_axis_check #(
                .POS_W(POS_W),
                .VEL_W(VEL_W)
            ) u_axis (
                .i_pos        (w_pos[b][a]),
                .i_vel        (r_vel[b][a]),
                .i_limit      ((a == 0) ? L_LIM_X : ((a == 1) ? L_LIM_Y : L_LIM_Z)),
                .o_reflect_lo (w_lo[b][a]),
                .o_reflect_hi (w_hi[b][a]),
                .o_neg_vel    (w_neg[b][a])
            );
        end

        assign vel_x[b*VEL_W +: VEL_W] = r_vel[b][0];
        assign vel_y[b*VEL_W +: VEL_W] = r_vel[b][1];
        assign vel_z[b*VEL_W +: VEL_W] = r_vel[b][2];
    end

    // Next-frame play update; events from every ball and axis are OR-merged.
    always_comb begin
        w_vel_nxt    = r_vel;
        w_active_nxt = r_active;
        w_wall       = 1'b0;
        w_pad        = 1'b0;
        w_miss       = 1'b0;
        w_pad_cnt    = 8'd0;
        w_score_inc  = 8'd0;
        for (int b = 0; b < N_BALLS; b++) begin
            if (r_active[b]) begin
                for (int a = 0; a < 2; a++) begin
                    if (w_lo[b][a] || w_hi[b][a]) begin
                        w_vel_nxt[b][a] = w_neg[b][a];
                        w_wall          = 1'b1;
                    end
                end
                if (w_lo[b][2]) begin
                    w_vel_nxt[b][2] = w_neg[b][2];
                    w_wall          = 1'b1;
                    w_score_inc     = w_score_inc + 8'd1;
                end else if (w_hi[b][2]) begin
                    if (w_in_pad[b]) begin
                        w_vel_nxt[b][2] = w_neg[b][2];
                        w_pad           = 1'b1;
                        w_pad_cnt       = w_pad_cnt + 8'd1;
                    end else begin
                        w_miss          = 1'b1;
                        w_active_nxt[b] = 1'b0;
                        for (int a = 0; a < 3; a++)
                            w_vel_nxt[b][a] = '0;
                    end
                end
            end
        end

        w_hit_sum = 8'(r_hit_cnt) + w_pad_cnt;
        w_speedup = w_hit_sum >= 8'(HITS_PER_SPEEDUP);
        w_hit_nxt = w_speedup ? HC_W'(w_hit_sum - 8'(HITS_PER_SPEEDUP)) : HC_W'(w_hit_sum);
        if (w_speedup) begin
            for (int b = 0; b < N_BALLS; b++)
                for (int a = 0; a < 3; a++)
                    w_vel_nxt[b][a] = speed_up(w_vel_nxt[b][a]);
        end

        w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(w_score_inc);
        w_score_nxt = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
    end

    // Game FSM plus all registered outputs; pulses default low every frame.
    always_ff @(posedge frame_clk or negedge level_rst_n) begin
        if (!level_rst_n) begin
            r_state   <= IDLE;
            r_active  <= '0;
            r_score   <= '0;
            r_hit_cnt <= '0;
            r_wall    <= 1'b0;
            r_pad     <= 1'b0;
            r_miss    <= 1'b0;
            for (int b = 0; b < N_BALLS; b++)
                for (int a = 0; a < 3; a++)
                    r_vel[b][a] <= '0;
        end else begin
            r_wall <= 1'b0;
            r_pad  <= 1'b0;
            r_miss <= 1'b0;
            case (r_state)
                IDLE, OVER: begin
                    if (serve && !pause) begin
                        r_state   <= PLAY;
                        r_active  <= '1;
                        r_score   <= '0;
                        r_hit_cnt <= '0;
                        for (int b = 0; b < N_BALLS; b++)
                            for (int a = 0; a < 3; a++)
                                r_vel[b][a] <= VEL_W'(base_speed(lvl_num));
                    end
                end
                PLAY: begin
                    if (pause) begin
                        r_state <= PAUSED;
                    end else begin
                        r_vel     <= w_vel_nxt;
                        r_active  <= w_active_nxt;
                        r_score   <= w_score_nxt;
                        r_hit_cnt <= w_hit_nxt;
                        r_wall    <= w_wall;
                        r_pad     <= w_pad;
                        r_miss    <= w_miss;
                        if (w_active_nxt == '0)
                            r_state <= OVER;
                    end
                end
                PAUSED: begin
                    if (!pause)
                        r_state <= PLAY;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ball_active = r_active;
    assign score       = r_score;
    assign wall_hit    = r_wall;
    assign paddle_hit  = r_pad;
    assign miss        = r_miss;
    assign game_state  = r_state;

endmodule

// File: tb/tb_ball_collision_engine.sv
// Directed bench for ball_collision_engine: a vector table for the basic
// reflections and speed-up, then hand sequences for score, pause and misses.
module tb_ball_collision_engine;

    localparam int NB = 2;
    localparam int PW = 10;
    localparam int VW = 6;

    logic             frame_clk = 1'b0;
    logic             level_rst_n;
    logic             pause;
    logic             serve;
    logic [7:0]       lvl_num;
    logic [NB*PW-1:0] pos_x, pos_y, pos_z;
    logic [PW-1:0]    paddle_x, paddle_y;
    logic [NB*VW-1:0] vel_x, vel_y, vel_z;
    logic [NB-1:0]    ball_active;
    logic [7:0]       score;
    logic             wall_hit, paddle_hit, miss;
    logic [1:0]       game_state;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int serve; int pause; int lvl;
        int px0; int py0; int pz0; int px1; int py1; int pz1;
        int st; int act;
        int vx0; int vy0; int vz0; int vx1; int vy1; int vz1;
        int wall; int pad; int mis; int sc;
    } vec_t;

    ball_collision_engine dut (
        .frame_clk   (frame_clk),
        .level_rst_n (level_rst_n),
        .pause       (pause),
        .serve       (serve),
        .lvl_num     (lvl_num),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_z       (pos_z),
        .paddle_x    (paddle_x),
        .paddle_y    (paddle_y),
        .vel_x       (vel_x),
        .vel_y       (vel_y),
        .vel_z       (vel_z),
        .ball_active (ball_active),
        .score       (score),
        .wall_hit    (wall_hit),
        .paddle_hit  (paddle_hit),
        .miss        (miss),
        .game_state  (game_state)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic int velOf(input int axis, input int b);
        logic signed [VW-1:0] v;
        if (axis == 0)      v = vel_x[b*VW +: VW];
        else if (axis == 1) v = vel_y[b*VW +: VW];
        else                v = vel_z[b*VW +: VW];
        return int'(v);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Drive one frame of inputs, then sample just after the following edge.
    task automatic applyStimulus(input int s, input int p, input int lvl,
                                 input int px0, input int py0, input int pz0,
                                 input int px1, input int py1, input int pz1);
        serve   = s[0];
        pause   = p[0];
        lvl_num = lvl[7:0];
        pos_x   = {px1[PW-1:0], px0[PW-1:0]};
        pos_y   = {py1[PW-1:0], py0[PW-1:0]};
        pos_z   = {pz1[PW-1:0], pz0[PW-1:0]};
        @(posedge frame_clk);
        #1;
    endtask

    task automatic checkVector(input string tag, input vec_t v);
        checkOutput({tag, " state"},  int'(game_state), v.st);
        checkOutput({tag, " active"}, int'(ball_active), v.act);
        checkOutput({tag, " vx0"},    velOf(0, 0), v.vx0);
        checkOutput({tag, " vy0"},    velOf(1, 0), v.vy0);
        checkOutput({tag, " vz0"},    velOf(2, 0), v.vz0);
        checkOutput({tag, " vx1"},    velOf(0, 1), v.vx1);
        checkOutput({tag, " vy1"},    velOf(1, 1), v.vy1);
        checkOutput({tag, " vz1"},    velOf(2, 1), v.vz1);
        checkOutput({tag, " wall"},   int'(wall_hit), v.wall);
        checkOutput({tag, " paddle"}, int'(paddle_hit), v.pad);
        checkOutput({tag, " miss"},   int'(miss), v.mis);
        checkOutput({tag, " score"},  int'(score), v.sc);
    endtask

    initial begin
        vec_t tbl [10];
        int s0, s1, mag, hits, sc, z0, z1;

        // Base speed 1, paddle at (100,100); (150,150,64) is a quiet spot.
        tbl[0] = '{1,0,1, 150,150,64, 150,150,64,  1,3,  1, 1, 1, 1,1,1, 0,0,0,0};
        tbl[1] = '{0,0,1, 639,150,64, 150,150,64,  1,3, -1, 1, 1, 1,1,1, 1,0,0,0};
        tbl[2] = '{0,0,1, 150,150,64, 150,150,64,  1,3, -1, 1, 1, 1,1,1, 0,0,0,0};
        tbl[3] = '{0,0,1, 150,150,127, 150,150,64, 1,3, -1, 1,-1, 1,1,1, 0,1,0,0};
        tbl[4] = '{0,0,1, 150,150,0, 150,150,64,   1,3, -1, 1, 1, 1,1,1, 1,0,0,1};
        tbl[5] = '{0,0,1, 150,150,127, 150,150,64, 1,3, -1, 1,-1, 1,1,1, 0,1,0,1};
        tbl[6] = '{0,0,1, 150,150,0, 150,150,64,   1,3, -1, 1, 1, 1,1,1, 1,0,0,2};
        tbl[7] = '{0,0,1, 150,150,127, 150,150,64, 1,3, -1, 1,-1, 1,1,1, 0,1,0,2};
        tbl[8] = '{0,0,1, 150,150,0, 150,150,64,   1,3, -1, 1, 1, 1,1,1, 1,0,0,3};
        tbl[9] = '{0,0,1, 150,150,127, 150,150,64, 1,3, -2, 2,-2, 2,2,2, 0,1,0,3};

        level_rst_n = 1'b0;
        paddle_x    = 10'd100;
        paddle_y    = 10'd100;
        serve       = 1'b0;
        pause       = 1'b0;
        lvl_num     = 8'd0;
        pos_x       = {10'd150, 10'd150};
        pos_y       = {10'd150, 10'd150};
        pos_z       = {10'd64, 10'd64};
        repeat (2) @(posedge frame_clk);
        #1;
        checkOutput("reset state",  int'(game_state), 0);
        checkOutput("reset active", int'(ball_active), 0);
        checkOutput("reset score",  int'(score), 0);
        checkOutput("reset vz0",    velOf(2, 0), 0);
        checkOutput("reset pulses", int'({wall_hit, paddle_hit, miss}), 0);
        level_rst_n = 1'b1;

        applyStimulus(1, 0, 3, 150,150,64, 150,150,64);
        checkOutput("lvl3 serve state",  int'(game_state), 1);
        checkOutput("lvl3 serve active", int'(ball_active), 3);
        checkOutput("lvl3 serve vx0",    velOf(0, 0), 2);
        checkOutput("lvl3 serve vz1",    velOf(2, 1), 2);
        applyStimulus(0, 0, 3, 150,150,127, 150,150,64);
        checkOutput("lvl3 paddle vz0", velOf(2, 0), -2);
        checkOutput("lvl3 paddle hit", int'(paddle_hit), 1);
        applyStimulus(0, 0, 3, 150,150,0, 150,150,64);
        checkOutput("lvl3 back vz0",   velOf(2, 0), 2);
        checkOutput("lvl3 back score", int'(score), 1);

        // Asynchronous reset landing between clock edges mid-play.
        #3;
        level_rst_n = 1'b0;
        #1;
        checkOutput("async rst state",  int'(game_state), 0);
        checkOutput("async rst score",  int'(score), 0);
        checkOutput("async rst vz0",    velOf(2, 0), 0);
        checkOutput("async rst vx1",    velOf(0, 1), 0);
        checkOutput("async rst active", int'(ball_active), 0);
        @(posedge frame_clk);
        #1;
        level_rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].serve, tbl[i].pause, tbl[i].lvl,
                          tbl[i].px0, tbl[i].py0, tbl[i].pz0,
                          tbl[i].px1, tbl[i].py1, tbl[i].pz1);
            checkVector($sformatf("row%0d", i), tbl[i]);
        end

        // One ball on the paddle and the other on the back wall every frame.
        s0 = -1; s1 = 1; mag = 2; hits = 0; sc = 3;
        for (int i = 0; i < 400 && sc < 254; i++) begin
            z0 = (s0 > 0) ? 127 : 0;
            z1 = (s1 > 0) ? 127 : 0;
            applyStimulus(0, 0, 1, 150,150,z0, 150,150,z1);
            s0 = -s0; s1 = -s1; sc++; hits++;
            if (hits == 4) begin
                hits = 0;
                if (mag < 7) mag++;
            end
            checkOutput($sformatf("rally%0d vz0", i), velOf(2, 0), s0 * mag);
            checkOutput($sformatf("rally%0d vz1", i), velOf(2, 1), s1 * mag);
            checkOutput($sformatf("rally%0d vx0", i), velOf(0, 0), -mag);
            checkOutput($sformatf("rally%0d score", i), int'(score), sc);
            checkOutput($sformatf("rally%0d pulses", i), int'({wall_hit, paddle_hit}), 3);
        end
        checkOutput("rally reached 254", int'(score), 254);

        z0 = (s0 > 0) ? 127 : 64;
        z1 = (s1 > 0) ? 127 : 64;
        applyStimulus(0, 0, 1, 150,150,z0, 150,150,z1);
        checkOutput("align vz0",   velOf(2, 0), -7);
        checkOutput("align vz1",   velOf(2, 1), -7);
        checkOutput("align wall",  int'(wall_hit), 0);
        applyStimulus(0, 0, 1, 150,150,0, 150,150,0);
        checkOutput("double back score", int'(score), 255);
        checkOutput("double back vz1",   velOf(2, 1), 7);
        checkOutput("double back wall",  int'(wall_hit), 1);
        applyStimulus(0, 0, 1, 150,150,127, 150,150,127);
        checkOutput("double paddle vz0", velOf(2, 0), -7);
        applyStimulus(0, 0, 1, 150,150,0, 150,150,0);
        checkOutput("saturated score", int'(score), 255);

        applyStimulus(0, 1, 1, 150,150,127, 150,150,127);
        checkOutput("pause state",  int'(game_state), 2);
        checkOutput("pause vz0",    velOf(2, 0), 7);
        checkOutput("pause pulses", int'({wall_hit, paddle_hit, miss}), 0);
        applyStimulus(1, 1, 1, 150,150,0, 150,150,0);
        checkOutput("pause serve state", int'(game_state), 2);
        checkOutput("pause hold score",  int'(score), 255);
        checkOutput("pause hold wall",   int'(wall_hit), 0);
        applyStimulus(0, 0, 1, 150,150,64, 150,150,64);
        checkOutput("resume state", int'(game_state), 1);
        checkOutput("resume vx0",   velOf(0, 0), -7);
        checkOutput("resume vz1",   velOf(2, 1), 7);

        applyStimulus(0, 0, 1, 0,0,127, 150,150,64);
        checkOutput("miss0 flag",   int'(miss), 1);
        checkOutput("miss0 active", int'(ball_active), 2);
        checkOutput("miss0 vx0",    velOf(0, 0), 0);
        checkOutput("miss0 vz0",    velOf(2, 0), 0);
        checkOutput("miss0 vz1",    velOf(2, 1), 7);
        checkOutput("miss0 state",  int'(game_state), 1);
        applyStimulus(0, 0, 1, 639,150,0, 0,0,127);
        checkOutput("miss1 state",  int'(game_state), 3);
        checkOutput("miss1 active", int'(ball_active), 0);
        checkOutput("miss1 flag",   int'(miss), 1);
        checkOutput("miss1 wall",   int'(wall_hit), 0);
        checkOutput("miss1 vz1",    velOf(2, 1), 0);
        applyStimulus(0, 0, 1, 150,150,64, 150,150,64);
        checkOutput("over state", int'(game_state), 3);
        checkOutput("over miss",  int'(miss), 0);
        applyStimulus(1, 0, 5, 150,150,64, 150,150,64);
        checkOutput("reserve state",  int'(game_state), 1);
        checkOutput("reserve score",  int'(score), 0);
        checkOutput("reserve vx0",    velOf(0, 0), 2);
        checkOutput("reserve active", int'(ball_active), 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ball_collision_engine.md
Name: ball_collision_engine

Overview:
Multi-ball successor to the single-ball collision block in the 3D Pong game datapath. Each frame it checks up to N_BALLS ball positions against a parametrised arena and paddle and updates signed per-ball velocities. It keeps game state, score, speed-up and miss tracking. It sits between the ball position integrators, which consume vel_*, and the level/score controller, which consumes the event pulses.

Parameters:
N_BALLS, 2, number of independent ball channels
POS_W, 10, position width, unsigned
VEL_W, 6, velocity width, two's complement
ARENA_X, 640, x extent; legal 0..ARENA_X-1
ARENA_Y, 480, y extent
ARENA_Z, 128, z depth; z=ARENA_Z-1 is the paddle plane, z=0 is the back wall
PAD_W, 200, paddle width in x
PAD_H, 150, paddle height in y
SCORE_W, 8, score width
HITS_PER_SPEEDUP, 4, paddle hits between speed increments
VEL_MAX, 7, maximum velocity magnitude per axis

Ports:
frame_clk  in  1  frame clock; all state updates on posedge
level_rst_n  in  1  asynchronous active-low reset
pause  in  1  freeze play; velocities are held
serve  in  1  start or restart play
lvl_num  in  8  level; base speed is 2 for lvl_num>=3, else 1
pos_x  in  N_BALLS*POS_W  packed ball x positions; ball i at [i*POS_W +: POS_W]
pos_y  in  N_BALLS*POS_W  packed ball y positions
pos_z  in  N_BALLS*POS_W  packed ball z positions
paddle_x  in  POS_W  paddle left edge
paddle_y  in  POS_W  paddle top edge
vel_x  out  N_BALLS*VEL_W  signed x velocities
vel_y  out  N_BALLS*VEL_W  signed y velocities
vel_z  out  N_BALLS*VEL_W  signed z velocities
ball_active  out  N_BALLS  ball i is in play
score  out  SCORE_W  back-wall hits, saturating
wall_hit  out  1  one-frame pulse on any wall reflection
paddle_hit  out  1  one-frame pulse on any paddle return
miss  out  1  one-frame pulse on any ball lost
game_state  out  2  current FSM state encoding

Behaviour:
- Clock and reset: one clock, frame_clk. Reset is asynchronous and active-low (level_rst_n). Reset may assert at any time, including mid-play.
- Reset values: state IDLE, all vel 0, ball_active 0, score 0, all pulses 0, hit counter 0.
- All outputs are registered. A response appears at the posedge following the frame whose inputs caused it. Pulses last exactly one frame.
- FSM states: IDLE=0, PLAY=1, PAUSED=2, OVER=3.
- IDLE or OVER, serve=1 and pause=0 -> PLAY. On this transition: every vel axis of every ball loads +base; ball_active is set to all ones; score clears to 0; hit counter clears to 0.
- PLAY, pause=1 -> PAUSED. Velocities and score are held, not reset. No pulses while PAUSED.
- PAUSED, pause=0 -> PLAY. A serve seen while PAUSED is ignored.
- PLAY, all ball_active bits 0 -> OVER, entered on the same edge the last miss registers. vel is 0 in OVER.
- Per-axis prediction for each active ball in PLAY:
  - nxt = pos + sign-extended vel, computed in POS_W+2 bits signed.
  - X/Y axes: if nxt<0 or nxt>=ARENA, vel <= -vel and wall_hit is raised.
  - Z axis, nxt<0: vel_z <= -vel_z, wall_hit is raised, and the ball contributes +1 to score.
  - Z axis, nxt>=ARENA_Z with the current pos inside [paddle_x, paddle_x+PAD_W) x [paddle_y, paddle_y+PAD_H): vel_z <= -vel_z, paddle_hit is raised, and the hit counter increments.
  - Z axis, nxt>=ARENA_Z with pos outside the paddle: miss is raised, the ball's active bit clears, and all three of its vel axes go to 0.
- Pulse OR: pulse flags are OR-accumulated across all balls and axes. A non-hitting axis never clears a flag raised by another axis.
- Score: score increments by the number of balls hitting the back wall that frame, saturating at 2^SCORE_W-1.
- Speed-up: when the hit counter reaches HITS_PER_SPEEDUP it wraps to 0. On that same edge every nonzero vel magnitude increments by 1, capped at VEL_MAX, with the sign preserved. The sign used is the post-reflection sign of that frame.
- Inactive balls: their pos inputs are ignored and their vel stays 0.
- lvl_num is sampled only at serve.

Decomposition:
- pong_pkg holds: the state_t enum (IDLE/PLAY/PAUSED/OVER), a base_speed(lvl_num) function, and default arena and paddle constants shared with the renderer.
- Sub-module ball_axis_check: combinational. Inputs are pos, vel and limit. Outputs are reflect_lo, reflect_hi and neg_vel. It is instantiated 3*N_BALLS times.
- The top level holds the FSM, the registers, the speed-up counter and the score.

Test Plan:
- Reset with level_rst_n=0 mid-PLAY, asynchronously between edges -> all vel 0, score 0, game_state=0 immediately.
- lvl_num=3, serve=1 -> next edge game_state=1, every vel axis=+2, ball_active=2'b11.
- Ball0 pos_x=639 with vel_x=+1; ball1 y in bounds -> vel_x0 becomes -1 and wall_hit=1 for one frame. Also check that ball1's non-hit does not clear wall_hit.
- Ball0 pos_z=127, vel_z=+1, paddle_x=100, paddle_y=100, ball at (150,150) -> vel_z0=-1, paddle_hit=1. After 4 such hits with vel=±1 -> all magnitudes become 2. Continued hits saturate at 7.
- Ball0 at (0,0,127) outside the paddle, vel_z=+1 -> miss=1, ball_active[0]=0, vel0=0. Then ball1 misses -> game_state=3.
- Both balls reach z=0 on the same frame with score=254 -> score=255 and stays saturated. Then pause=1 -> vel held, no pulses; pause=0 -> play resumes with the same velocities.
